bin2bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble).

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Latency: none (types, constants and an elaboration-time function only).
// Backpressure: not applicable.
package bcd_pkg;

  // One packed BCD digit (0..9 in normal operation).
  typedef logic [3:0] bcd_digit_t;

  // Converter sequencing: capture, one shift per input bit, then publish.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  // Largest value representable in 'digits' BCD digits (10^digits - 1).
  // Only evaluated at elaboration, so the loop costs no hardware.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
// Latency: combinational. Backpressure: not applicable.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  bcd_digit_t d;

  // A digit never exceeds 9 before adjustment, so the result stays within 12.
  always_comb begin
    d        = digit;
    adjusted = (d >= 4'd5) ? (d + 4'd3) : d;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Latency: start accepted on edge k -> done pulse in the cycle after edge k+IN_W+1.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Build option BCD_SATURATE_EN: on overflow the result loads all-9 digits instead of bin mod 10^DIGITS.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int               BCD_W    = 4 * DIGITS;
  localparam int               CNT_W    = $clog2(IN_W + 1);
  localparam logic [63:0]      MAX_VAL  = bcd_max(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject configurations that cannot produce a meaningful result.
  generate
    if (DIGITS < 1) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS must be at least 1");
    end
    if (IN_W < 1) begin : g_bad_width
      $error("bin2bcd_seq: IN_W must be at least 1");
    end
  endgenerate

  b2b_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic             ovf_pend;
  logic             bin_over;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;
  logic             done_q;
  logic [63:0]      bin_ext;

`ifdef BCD_SATURATE_EN
  logic [BCD_W-1:0] sat_val;
  assign sat_val = {DIGITS{4'h9}};
`endif

  // One correction stage per digit; all digits are adjusted in parallel each shift.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit    (scratch[4*g +: 4]),
        .adjusted (adj[4*g +: 4])
      );
    end
  endgenerate

  // Next scratch: adjusted digits shifted left, next binary MSB enters at bit 0.
  // The top digit's carry falls off the end, which yields bin mod 10^DIGITS.
  always_comb begin
    scratch_nxt = (adj << 1) | {{(BCD_W-1){1'b0}}, shreg[IN_W-1]};
  end

  // Range check against the elaboration-time maximum.
  always_comb begin
    bin_ext  = 64'(bin);
    bin_over = (bin_ext > MAX_VAL);
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            cnt      <= CNT_LOAD;
            ovf_pend <= bin_over;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Outputs change only here, so no partial result is ever visible.
          done_q <= 1'b1;
          ovf_q  <= ovf_pend;
`ifdef BCD_SATURATE_EN
          bcd_q  <= ovf_pend ? sat_val : scratch;
`else
          bcd_q  <= scratch;
`endif
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy covers the whole conversion including the publish cycle.
  always_comb begin
    busy     = (state != IDLE);
    done     = done_q;
    bcd      = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq (IN_W=14, DIGITS=4).
// Driver pushes the reference result per accepted start; a monitor pops on done.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  bin2bcd_seq #(.IN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: decimal digits of the value by plain division.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int m;
    r = 16'h0;
`ifdef BCD_SATURATE_EN
    if (v > 9999) return 16'h9999;
`endif
    m = v % 10000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input int v);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.ovf = (v > 9999);
    e.acc = cyc + 1;
    return e;
  endfunction

  // Monitor: checks each done against the scoreboard and that outputs hold otherwise.
  initial begin
    logic [16:0] hold;
    exp_t e;
    hold = 17'h0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = q.pop_front();
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("latency", 32'(cyc - e.acc), 32'd15);
        end
        hold = {overflow, bcd};
      end else begin
        if (rst) hold = 17'h0;
        check("hold", 32'({overflow, bcd}), 32'(hold));
      end
    end
  end

  // Watchdog keeps the run bounded even if the DUT stalls.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input int v);
    int t;
    t = 0;
    while (busy && t < 40) begin
      step(1);
      t++;
    end
    if (busy) begin
      check("issue_wait_busy", 32'(busy), 32'h0);
    end else begin
      start = 1'b1;
      bin   = 14'(v);
      q.push_back(make_exp(v));
      step(1);
      start = 1'b0;
      bin   = 14'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 100) begin
      step(1);
      t++;
    end
    check("drain_queue", 32'(q.size()), 32'h0);
  endtask

  initial begin
    int n;
    int it;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 14'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    step(1);

    // Zero input; busy must stay high for exactly 15 cycles.
    issue(0);
    for (int i = 0; i < 15; i++) begin
      check("busy_high", 32'(busy), 32'h1);
      step(1);
    end
    check("busy_low", 32'(busy), 32'h0);
    drain();

    // Directed values including the largest non-overflowing one.
    issue(9999); drain();
    issue(1234); drain();
    issue(5);    drain();

    // Starts during SHIFT (busy cycle 3) and DONE (busy cycle 15) are ignored.
    issue(1234);
    step(2);
    start = 1'b1; bin = 14'd42;
    step(1);
    start = 1'b0;
    step(11);
    start = 1'b1; bin = 14'd42;
    step(1);
    start = 1'b0;
    drain();

    // Overflow cases.
    issue(12345); drain();
    issue(10000); drain();
    issue(16383); drain();

    // Abort: reset during shift cycle 5 clears results and suppresses done.
    issue(777); drain();
    issue(500);
    step(4);
    rst = 1'b1;
    void'(q.pop_back());
    step(1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_bcd", 32'(bcd), 32'h0);
    rst = 1'b0;
    step(20);
    issue(500); drain();

    // Random values with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      issue(int'($urandom_range(0, 16383)));
      step(int'($urandom_range(0, 3)));
    end
    drain();

    // start held high, bin changing every cycle: back-to-back conversions.
    n  = 0;
    it = 0;
    bin   = 14'h0;
    start = 1'b1;
    while (n < 150 && it < 3000) begin
      bin = 14'((int'(bin) + 37) % 16384);
      if (!busy) begin
        q.push_back(make_exp(int'(bin)));
        n++;
      end
      step(1);
      it++;
    end
    start = 1'b0;
    check("held_count", 32'(n), 32'd150);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
